// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Buffers dispatched integer-ALU micro-ops, captures missing operands from
//   the CDB, and presents the oldest micro-op with both operands ready to the ALU.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              drop every buffered micro-op (mispredict recovery)
//   dispatch_*         incoming micro-op (valid/ready handshake)
//   cdb_*              result broadcast used for wakeup and dispatch bypass
//   issue_*            selected micro-op towards the ALU (valid/ready handshake)
//   occupancy          number of busy entries

package alu_rs_pkg;
  typedef enum logic [3:0] {
    noALU, addALU, subALU, andALU, orALU, xorALU,
    sllALU, srlALU, sraALU, sltALU, sltuALU
  } ALU_operation_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  ALU_operation_t               dispatch_op,
  input  logic                         dispatch_src1_valid,
  input  logic [31:0]                  dispatch_src1_data,
  input  logic [TAG_W-1:0]             dispatch_src1_tag,
  input  logic                         dispatch_src2_valid,
  input  logic [31:0]                  dispatch_src2_data,
  input  logic [TAG_W-1:0]             dispatch_src2_tag,
  input  logic [TAG_W-1:0]             dispatch_dest_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output ALU_operation_t               issue_op,
  output logic [31:0]                  issue_input1_data,
  output logic [31:0]                  issue_input2_data,
  output logic [TAG_W-1:0]             issue_dest_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    ALU_operation_t   op;
    logic             v1;
    logic [31:0]      d1;
    logic [TAG_W-1:0] t1;
    logic             v2;
    logic [31:0]      d2;
    logic [TAG_W-1:0] t2;
    logic [TAG_W-1:0] dest;
  } entry_t;

  entry_t                          ent [DEPTH];
  logic [DEPTH-1:0]                busy;
  // age[i][j] set: entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0]     age;

  logic [DEPTH-1:0] rdy, sel, clr;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire, issue_fire;
  entry_t           new_ent;

  // select: a ready entry wins if no other ready entry is older than it
  always_comb begin
    for (int i = 0; i < DEPTH; i++) rdy[i] = busy[i] & ent[i].v1 & ent[i].v2;
    for (int i = 0; i < DEPTH; i++) sel[i] = rdy[i] & ~|(age[i] & rdy);
  end

  assign issue_valid = |rdy;
  assign issue_fire  = issue_valid & issue_ready;
  assign clr         = sel & {DEPTH{issue_fire}};

  always_comb begin
    issue_op          = noALU;
    issue_input1_data = '0;
    issue_input2_data = '0;
    issue_dest_tag    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        issue_op          = ent[i].op;
        issue_input1_data = ent[i].d1;
        issue_input2_data = ent[i].d2;
        issue_dest_tag    = ent[i].dest;
      end
    end
  end

  // lowest-index free slot, from registered busy bits only
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) if (!busy[i]) free_idx = IDX_W'(i);
  end

  assign dispatch_ready = (occupancy < OCC_W'(DEPTH));
  assign disp_fire      = dispatch_valid & dispatch_ready;

  // dispatch bypass: a source broadcast in the dispatch cycle is captured directly
  always_comb begin
    new_ent.op   = dispatch_op;
    new_ent.t1   = dispatch_src1_tag;
    new_ent.t2   = dispatch_src2_tag;
    new_ent.dest = dispatch_dest_tag;
    new_ent.v1   = dispatch_src1_valid | (cdb_valid & (cdb_tag == dispatch_src1_tag));
    new_ent.d1   = dispatch_src1_valid ? dispatch_src1_data : cdb_data;
    new_ent.v2   = dispatch_src2_valid | (cdb_valid & (cdb_tag == dispatch_src2_tag));
    new_ent.d2   = dispatch_src2_valid ? dispatch_src2_data : cdb_data;
  end

  // payload: wakeup for busy entries, write on dispatch (no reset needed)
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && busy[i]) begin
        if (!ent[i].v1 && ent[i].t1 == cdb_tag) begin
          ent[i].v1 <= 1'b1;
          ent[i].d1 <= cdb_data;
        end
        if (!ent[i].v2 && ent[i].t2 == cdb_tag) begin
          ent[i].v2 <= 1'b1;
          ent[i].d2 <= cdb_data;
        end
      end
    end
    if (disp_fire) ent[free_idx] <= new_ent;
  end

  // control: busy bits, age matrix, occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy      <= '0;
      age       <= '0;
      occupancy <= '0;
    end else begin
      busy <= (busy & ~clr) | (disp_fire ? (DEPTH'(1) << free_idx) : '0);
      if (disp_fire) begin
        // stale column bits from the slot's previous life must not survive
        for (int i = 0; i < DEPTH; i++) age[i][free_idx] <= 1'b0;
        age[free_idx] <= busy & ~clr;
      end
      case ({disp_fire, issue_fire})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_reservation_station;
  import alu_rs_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 0;
  logic rst = 1, flush = 0;
  logic dispatch_valid = 0, dispatch_ready;
  ALU_operation_t dispatch_op = noALU;
  logic dispatch_src1_valid = 0, dispatch_src2_valid = 0;
  logic [31:0] dispatch_src1_data = 0, dispatch_src2_data = 0;
  logic [TAG_W-1:0] dispatch_src1_tag = 0, dispatch_src2_tag = 0, dispatch_dest_tag = 0;
  logic cdb_valid = 0;
  logic [TAG_W-1:0] cdb_tag = 0;
  logic [31:0] cdb_data = 0;
  logic issue_valid, issue_ready = 1;
  ALU_operation_t issue_op;
  logic [31:0] issue_input1_data, issue_input2_data;
  logic [TAG_W-1:0] issue_dest_tag;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op),
    .dispatch_src1_valid(dispatch_src1_valid), .dispatch_src1_data(dispatch_src1_data),
    .dispatch_src1_tag(dispatch_src1_tag),
    .dispatch_src2_valid(dispatch_src2_valid), .dispatch_src2_data(dispatch_src2_data),
    .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_dest_tag(dispatch_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_input1_data(issue_input1_data), .issue_input2_data(issue_input2_data),
    .issue_dest_tag(issue_dest_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: queue kept in program order (index 0 = oldest)
  typedef struct {
    ALU_operation_t op;
    bit v1; logic [31:0] d1; logic [TAG_W-1:0] t1;
    bit v2; logic [31:0] d2; logic [TAG_W-1:0] t2;
    logic [TAG_W-1:0] dest;
  } ment_t;
  ment_t q[$];
  bit started = 0;

  function automatic int first_ready();
    for (int i = 0; i < q.size(); i++) if (q[i].v1 && q[i].v2) return i;
    return -1;
  endfunction

  // model update at each clock edge from the inputs held across it
  initial forever begin
    @(posedge clk);
    started = 1;
    if (rst || flush) q.delete();
    else begin
      int  k;
      bit  dfire;
      ment_t n;
      k = first_ready();
      dfire = dispatch_valid && (q.size() < DEPTH);
      if (cdb_valid)
        foreach (q[i]) begin
          if (!q[i].v1 && q[i].t1 == cdb_tag) begin q[i].v1 = 1; q[i].d1 = cdb_data; end
          if (!q[i].v2 && q[i].t2 == cdb_tag) begin q[i].v2 = 1; q[i].d2 = cdb_data; end
        end
      if (k >= 0 && issue_ready) q.delete(k);
      if (dfire) begin
        n.op = dispatch_op; n.dest = dispatch_dest_tag;
        n.t1 = dispatch_src1_tag; n.t2 = dispatch_src2_tag;
        n.v1 = dispatch_src1_valid || (cdb_valid && cdb_tag == dispatch_src1_tag);
        n.d1 = dispatch_src1_valid ? dispatch_src1_data : cdb_data;
        n.v2 = dispatch_src2_valid || (cdb_valid && cdb_tag == dispatch_src2_tag);
        n.d2 = dispatch_src2_valid ? dispatch_src2_data : cdb_data;
        q.push_back(n);
      end
    end
  end

  // compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (started) begin
      int k;
      k = first_ready();
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("dispatch_ready", 32'(dispatch_ready), 32'(q.size() < DEPTH));
      chk("issue_valid", 32'(issue_valid), 32'(k >= 0));
      if (k >= 0) begin
        chk("issue_op", 32'(issue_op), 32'(q[k].op));
        chk("issue_in1", issue_input1_data, q[k].d1);
        chk("issue_in2", issue_input2_data, q[k].d2);
        chk("issue_dest", 32'(issue_dest_tag), 32'(q[k].dest));
      end else begin
        chk("idle_op", 32'(issue_op), 32'(noALU));
        chk("idle_in1", issue_input1_data, 0);
        chk("idle_in2", issue_input2_data, 0);
        chk("idle_dest", 32'(issue_dest_tag), 0);
      end
    end
  end

  task automatic step(); @(negedge clk); endtask

  task automatic idle();
    dispatch_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic disp(input ALU_operation_t op,
                      input bit v1, input logic [31:0] d1, input logic [TAG_W-1:0] t1,
                      input bit v2, input logic [31:0] d2, input logic [TAG_W-1:0] t2,
                      input logic [TAG_W-1:0] dest);
    dispatch_valid = 1; dispatch_op = op;
    dispatch_src1_valid = v1; dispatch_src1_data = d1; dispatch_src1_tag = t1;
    dispatch_src2_valid = v2; dispatch_src2_data = d2; dispatch_src2_tag = t2;
    dispatch_dest_tag = dest;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    // reset
    rst = 1; step(); step(); rst = 0;
    chk("rst_dready", 32'(dispatch_ready), 1);
    chk("rst_ivalid", 32'(issue_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_op", 32'(issue_op), 32'(noALU));

    // ready add issues the next cycle
    issue_ready = 1;
    disp(addALU, 1, 5, 0, 1, 7, 0, 3); step(); idle();
    chk("add_valid", 32'(issue_valid), 1);
    chk("add_in1", issue_input1_data, 5);
    chk("add_in2", issue_input2_data, 7);
    chk("add_dest", 32'(issue_dest_tag), 3);
    chk("add_occ1", 32'(occupancy), 1);
    step();
    chk("add_occ0", 32'(occupancy), 0);

    // CDB wakeup two cycles after dispatch
    disp(subALU, 0, 0, 2, 1, 9, 0, 6); step(); idle();
    chk("wake_wait0", 32'(issue_valid), 0);
    step();
    chk("wake_wait1", 32'(issue_valid), 0);
    cdb(2, 32'h10); step(); idle();
    chk("wake_valid", 32'(issue_valid), 1);
    chk("wake_in1", issue_input1_data, 32'h10);
    chk("wake_op", 32'(issue_op), 32'(subALU));
    step();

    // fill while stalled, then drain in order
    issue_ready = 0;
    for (int i = 0; i < 4; i++) begin
      disp(andALU, 1, 32'(i), 0, 1, 32'(i + 100), 0, 4'(10 + i)); step();
    end
    idle();
    chk("full_dready", 32'(dispatch_ready), 0);
    chk("full_occ", 32'(occupancy), 4);
    chk("full_head", 32'(issue_dest_tag), 10);
    issue_ready = 1; step();
    chk("drain_dready", 32'(dispatch_ready), 1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_order", 32'(issue_dest_tag), 32'(10 + i));
      step();
    end
    chk("drain_empty", 32'(issue_valid), 0);

    // dispatch bypass of src2
    disp(orALU, 1, 1, 0, 0, 0, 5, 9); cdb(5, 32'hAB); step(); idle();
    chk("byp_valid", 32'(issue_valid), 1);
    chk("byp_in2", issue_input2_data, 32'hAB);
    step();

    // younger ready op overtakes an older waiting one
    disp(xorALU, 0, 0, 1, 1, 2, 0, 7); step();
    disp(addALU, 1, 3, 0, 1, 4, 0, 8); step(); idle();
    chk("ooo_young", 32'(issue_dest_tag), 8);
    cdb(1, 32'h55); step(); idle();
    chk("ooo_old", 32'(issue_dest_tag), 7);
    chk("ooo_old_in1", issue_input1_data, 32'h55);
    step();

    // flush with a concurrent dispatch
    issue_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(sllALU, 1, 1, 0, 1, 2, 0, 4'(i)); step();
    end
    disp(srlALU, 1, 1, 0, 1, 1, 0, 15); flush = 1; step(); idle();
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_ivalid", 32'(issue_valid), 0);
    chk("flush_dready", 32'(dispatch_ready), 1);
    step();
    chk("flush_nocap", 32'(occupancy), 0);

    // random traffic, small tag space so wakeups and bypasses are frequent
    for (int c = 0; c < 3000; c++) begin
      dispatch_valid      = ($urandom_range(0, 1) == 1);
      dispatch_op         = ALU_operation_t'($urandom_range(1, 10));
      dispatch_src1_valid = ($urandom_range(0, 1) == 1);
      dispatch_src2_valid = ($urandom_range(0, 1) == 1);
      dispatch_src1_data  = $urandom;
      dispatch_src2_data  = $urandom;
      dispatch_src1_tag   = 4'($urandom_range(0, 7));
      dispatch_src2_tag   = 4'($urandom_range(0, 7));
      dispatch_dest_tag   = 4'($urandom_range(0, 15));
      cdb_valid           = ($urandom_range(0, 1) == 1);
      cdb_tag             = 4'($urandom_range(0, 7));
      cdb_data            = $urandom;
      issue_ready         = ($urandom_range(0, 9) < 6);
      flush               = ($urandom_range(0, 99) < 2);
      rst                 = ($urandom_range(0, 99) < 1);
      step();
    end
    idle(); rst = 0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
